// File: rtl/csync_separator_if.sv
// Composite-sync link: csync in, recovered active-low hsync/vsync out.
interface csync_separator_if;
  logic csync;
  logic hsync;
  logic vsync;

  modport master (output csync, input hsync, input vsync);
  modport slave  (input csync, output hsync, output vsync);
endinterface

// File: rtl/csync_separator.sv
// Splits composite sync into hsync/vsync: synchronizer, run-length vsync
// classifier and an hsync regeneration FSM with a Q-cycle serration delay.
module csync_separator #(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  csync_separator_if.slave     if_sync
);

  localparam logic [CNT_WIDTH-1:0] RL_T   = {1'b1, {(CNT_WIDTH-1){1'b0}}};
  localparam logic [CNT_WIDTH-2:0] PH_END = {1'b0, {(CNT_WIDTH-2){1'b1}}};

  typedef enum logic [1:0] {IDLE, DELAY, PULSE} state_t;

  logic                 r_s0, r_s1, r_s2;
  logic [CNT_WIDTH-1:0] r_rl;
  logic [CNT_WIDTH-1:0] w_rl_nxt;
  logic                 r_vsync, r_hsync;
  logic [CNT_WIDTH-2:0] r_ph;
  state_t               r_state;
  logic                 w_fall, w_rise, w_evt_n, w_evt_v;

  assign w_fall  = r_s2 & ~r_s1;
  assign w_rise  = ~r_s2 & r_s1;
  assign w_evt_n = r_vsync & w_fall;
  assign w_evt_v = ~r_vsync & w_rise;

  assign if_sync.hsync = r_hsync;
  assign if_sync.vsync = r_vsync;

  always_comb begin
    w_rl_nxt = r_rl;
    if (r_s1 != r_s2)    w_rl_nxt = CNT_WIDTH'(1);
    else if (r_rl != RL_T) w_rl_nxt = r_rl + CNT_WIDTH'(1);
  end

  // vsync takes the csync level on the same edge the run counter reaches T.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s0    <= 1'b1;
      r_s1    <= 1'b1;
      r_s2    <= 1'b1;
      r_rl    <= '0;
      r_vsync <= 1'b1;
    end else begin
      r_s0 <= if_sync.csync;
      r_s1 <= r_s0;
      r_s2 <= r_s1;
      r_rl <= w_rl_nxt;
      if (w_rl_nxt == RL_T) r_vsync <= r_s1;
    end
  end

  // Events override any state so closely spaced edges retrigger the pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ph    <= '0;
      r_hsync <= 1'b1;
    end else if (w_evt_n) begin
      r_state <= PULSE;
      r_ph    <= '0;
      r_hsync <= 1'b0;
    end else if (w_evt_v) begin
      r_state <= DELAY;
      r_ph    <= '0;
      r_hsync <= 1'b1;
    end else begin
      case (r_state)
        DELAY: begin
          if (r_ph == PH_END) begin
            r_state <= PULSE;
            r_ph    <= '0;
            r_hsync <= 1'b0;
          end else begin
            r_ph <= r_ph + 1'b1;
          end
        end
        PULSE: begin
          if (r_ph == PH_END) begin
            r_state <= IDLE;
            r_ph    <= '0;
            r_hsync <= 1'b1;
          end else begin
            r_ph <= r_ph + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_hsync <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_csync_separator.sv
// Directed bench for csync_separator at CNT_WIDTH=8 (Q=64, T=128).
module tb_csync_separator;
  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  csync_separator_if bus();

  csync_separator #(.CNT_WIDTH(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .if_sync (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive lvl for n1 edges then ~lvl for n2 edges; offsets count from the
  // first edge that samples lvl. Reports first hsync-low offset, number of
  // low edges, and the offset at which vsync first changes (-1 = none).
  task automatic line(input logic lvl, input int n1, input int n2,
                      input int ef, input int ec, input int ev, input string tag);
    int   first, cnt, vf;
    logic v0;
    first = -1; cnt = 0; vf = -1; v0 = bus.vsync;
    for (int e = 0; e < n1 + n2; e++) begin
      bus.csync = (e < n1) ? lvl : ~lvl;
      step();
      if (!bus.hsync) begin
        cnt++;
        if (first < 0) first = e;
      end
      if (vf < 0 && bus.vsync != v0) vf = e;
    end
    chk({tag, "_first"}, first, ef);
    chk({tag, "_cnt"}, cnt, ec);
    chk({tag, "_vflip"}, vf, ev);
  endtask

  initial begin
    int lows;
    n_chk = 0; n_fail = 0;
    rst_n = 1'b0;
    bus.csync = 1'b1;

    // reset held while csync toggles
    lows = 0;
    for (int i = 0; i < 12; i++) begin
      bus.csync = ~bus.csync;
      step();
      if (!bus.hsync || !bus.vsync) lows++;
    end
    chk("rst_hold", lows, 0);
    bus.csync = 1'b1;
    rst_n = 1'b1;
    chk("rst_h", int'(bus.hsync), 1);
    chk("rst_v", int'(bus.vsync), 1);
    lows = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (!bus.hsync || !bus.vsync) lows++;
    end
    chk("rst_nopulse", lows, 0);

    // normal lines
    line(1'b0, 64, 164, 2, 64, -1, "norm1");
    line(1'b0, 64, 164, 2, 64, -1, "norm2");

    // retrigger: second fall 20 cycles after the first restarts the pulse
    line(1'b0, 10, 10, 2, 18, -1, "retrig_a");
    line(1'b0, 64, 164, 0, 66, -1, "retrig_b");

    // vsync entry
    line(1'b0, 228, 0, 2, 64, 129, "entry");
    chk("rl_sat", int'(dut.r_rl), 128);

    // serrations: pulse delayed by Q after the rise, falls ignored
    line(1'b1, 64, 164, 66, 64, -1, "serr1");
    line(1'b1, 64, 164, 66, 64, -1, "serr2");

    // vsync exit, then a normal line
    line(1'b1, 228, 0, 66, 64, 129, "exit");
    line(1'b0, 64, 164, 2, 64, -1, "post_exit");

    // back into vsync, then async reset in the middle of a serration pulse
    line(1'b0, 228, 0, 2, 64, 129, "entry2");
    for (int e = 0; e < 80; e++) begin
      bus.csync = (e < 64) ? 1'b1 : 1'b0;
      step();
    end
    chk("pre_arst_h", int'(bus.hsync), 0);
    chk("pre_arst_v", int'(bus.vsync), 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_h", int'(bus.hsync), 1);
    chk("arst_v", int'(bus.vsync), 1);
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
